// File: rtl/ledger_reader.sv
// ledger_reader: fetches one ledger word from the shared RAM and streams it
// out LSB chunk first over a valid/ready handshake.
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   read_req            start pulse, sampled only while idle
//   access_sel          RAM region (0 = balances, 1 = hash chain), latched on accept
//   mem_busy            memory controller owns the RAM port this cycle
//   mem_result          RAM read data
//   rd_en               reader drives the RAM port (mux select + read request)
//   rd_access_type      latched access_sel presented to the RAM
//   byte_out, byte_idx  current chunk and its index
//   byte_valid          byte_out/byte_idx valid
//   byte_ready          consumer accepts the chunk
//   word_out            last captured word
//   busy                transaction in progress
//   done                one-cycle completion pulse
module ledger_reader #(
    parameter int unsigned WORD_WIDTH   = 48,
    parameter int unsigned BYTE_WIDTH   = 8,
    parameter int unsigned READ_LATENCY = 2   // 1..7
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  read_req,
    input  logic                  access_sel,
    input  logic                  mem_busy,
    input  logic [WORD_WIDTH-1:0] mem_result,
    output logic                  rd_en,
    output logic                  rd_access_type,
    output logic [BYTE_WIDTH-1:0] byte_out,
    output logic [2:0]            byte_idx,
    output logic                  byte_valid,
    input  logic                  byte_ready,
    output logic [WORD_WIDTH-1:0] word_out,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned NUM_BYTES = WORD_WIDTH / BYTE_WIDTH;
    localparam logic [2:0]  LAST_IDX  = 3'(NUM_BYTES - 1);
    localparam logic [2:0]  LAT_LAST  = 3'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StIssue,
        StSend,
        StDone
    } state_e;

    state_e                state_q;
    logic [2:0]            lat_cnt_q;
    logic [WORD_WIDTH-1:0] shift_q;

    // The low chunk of the shift register is always the chunk on offer; it is
    // all zeros outside SEND because the full word has been shifted out.
    assign byte_out = shift_q[BYTE_WIDTH-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            lat_cnt_q      <= '0;
            shift_q        <= '0;
            rd_en          <= 1'b0;
            rd_access_type <= 1'b0;
            byte_idx       <= '0;
            byte_valid     <= 1'b0;
            word_out       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (read_req) begin
                        rd_access_type <= access_sel;
                        busy           <= 1'b1;
                        state_q        <= StArb;
                    end
                end

                StArb: begin
                    if (!mem_busy) begin
                        lat_cnt_q <= '0;
                        rd_en     <= 1'b1;
                        state_q   <= StIssue;
                    end
                end

                StIssue: begin
                    if (mem_busy) begin
                        // Write path has priority: drop the read and re-arbitrate.
                        rd_en     <= 1'b0;
                        lat_cnt_q <= '0;
                        state_q   <= StArb;
                    end else if (lat_cnt_q == LAT_LAST) begin
                        // rd_en has now been high for READ_LATENCY cycles.
                        rd_en      <= 1'b0;
                        lat_cnt_q  <= '0;
                        shift_q    <= mem_result;
                        word_out   <= mem_result;
                        byte_idx   <= '0;
                        byte_valid <= 1'b1;
                        state_q    <= StSend;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 3'd1;
                    end
                end

                StSend: begin
                    if (byte_ready) begin
                        shift_q <= shift_q >> BYTE_WIDTH;
                        if (byte_idx == LAST_IDX) begin
                            byte_valid <= 1'b0;
                            byte_idx   <= '0;
                            done       <= 1'b1;
                            state_q    <= StDone;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                        end
                    end
                end

                StDone: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
